// File: rtl/mem_stage_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module : mem_stage_pkg                                               |
// | Brief  : Shared types and widths for the memory-access pipe stage:   |
// |          controller state encoding, default bus-wait timeout and     |
// |          address / data / register-index widths.                     |
// | Rev    : 1.0  initial release                                        |
// +----------------------------------------------------------------------+
package mem_stage_pkg;

   localparam int c_ADDR_W          = 32;
   localparam int c_DATA_W          = 32;
   localparam int c_REG_W           = 5;
   localparam int c_TIMEOUT_DEFAULT = 15;

   typedef enum logic [0:0] {
      ST_IDLE = 1'b0,
      ST_BUSY = 1'b1
   } mem_state_e;

endpackage : mem_stage_pkg
`default_nettype wire

// File: rtl/mem_wait_timer.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module : mem_wait_timer                                              |
// | Brief  : Counts cycles spent waiting for a memory acknowledge.       |
// |          clear   - return the count to zero (dominates enable)       |
// |          enable  - advance the count by one this cycle               |
// |          expired - count has reached TIMEOUT-1 (combinational)       |
// | Rev    : 1.0  initial release                                        |
// +----------------------------------------------------------------------+
module mem_wait_timer
   import mem_stage_pkg::*;
#(
   parameter int TIMEOUT = c_TIMEOUT_DEFAULT
) (
   input  logic clk,
   input  logic rst,
   input  logic clear,
   input  logic enable,
   output logic expired
);

   // Largest value ever held is TIMEOUT-1; the controller leaves BUSY there.
   localparam int c_CNT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);

   logic [c_CNT_W-1:0] r_count;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_count <= '0;
      end else if (clear) begin
         r_count <= '0;
      end else if (enable) begin
         r_count <= r_count + 1'b1;
      end
   end

   assign expired = (r_count == c_CNT_W'(TIMEOUT - 1));

endmodule : mem_wait_timer
`default_nettype wire

// File: rtl/mem_access_stage.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module : mem_access_stage                                            |
// | Brief  : MEM pipeline stage. Non-memory ops pass EX/MEM -> MEM/WB in |
// |          one cycle. Aligned loads/stores issue a registered request  |
// |          and stall upstream until mem_ack or a wait timeout.         |
// |          Misaligned accesses are dropped and flagged.                |
// | Ports  : clk, rst (async, active-high)                               |
// |          XM_* / ALUout   - EX/MEM register inputs                    |
// |          mem_*           - data-memory request / response            |
// |          MW_*            - MEM/WB register outputs                   |
// |          mem_stall       - hold EX/MEM upstream                      |
// |          pc_redirect/redirect_pc - branch redirect                   |
// |          misalign_err/bus_err    - sticky error flags                |
// | Rev    : 1.0  initial release                                        |
// +----------------------------------------------------------------------+
module mem_access_stage
   import mem_stage_pkg::*;
#(
   parameter int TIMEOUT = c_TIMEOUT_DEFAULT
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                XM_MemtoReg,
   input  logic                XM_RegWrite,
   input  logic                XM_MemRead,
   input  logic                XM_MemWrite,
   input  logic                XM_branch,
   input  logic [c_ADDR_W-1:0] ALUout,
   input  logic [c_DATA_W-1:0] XM_MD,
   input  logic [c_REG_W-1:0]  XM_RD,
   input  logic [c_ADDR_W-1:0] XM_BT,
   output logic                mem_req,
   output logic                mem_we,
   output logic [c_ADDR_W-1:0] mem_addr,
   output logic [c_DATA_W-1:0] mem_wdata,
   input  logic                mem_ack,
   input  logic [c_DATA_W-1:0] mem_rdata,
   output logic                MW_MemtoReg,
   output logic                MW_RegWrite,
   output logic [c_ADDR_W-1:0] MW_ALUout,
   output logic [c_DATA_W-1:0] MW_MDout,
   output logic [c_REG_W-1:0]  MW_RD,
   output logic                mem_stall,
   output logic                pc_redirect,
   output logic [c_ADDR_W-1:0] redirect_pc,
   output logic                misalign_err,
   output logic                bus_err
);

   mem_state_e r_state;
   mem_state_e w_next_state;

   logic w_access;
   logic w_aligned;
   logic w_start;
   logic w_finish;
   logic w_abort;
   logic w_expired;

   // Writeback fields captured when the request is issued, released on ack.
   logic                r_lat_memtoreg;
   logic                r_lat_regwrite;
   logic [c_ADDR_W-1:0] r_lat_aluout;
   logic [c_REG_W-1:0]  r_lat_rd;

   assign w_access  = XM_MemRead | XM_MemWrite;
   assign w_aligned = (ALUout[1:0] == 2'b00);

   mem_wait_timer #(
      .TIMEOUT (TIMEOUT)
   ) u_wait_timer (
      .clk     (clk),
      .rst     (rst),
      .clear   (r_state == ST_IDLE),
      .enable  ((r_state == ST_BUSY) && !mem_ack),
      .expired (w_expired)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_next_state;
      end
   end

   always_comb begin
      w_next_state = r_state;
      mem_stall    = 1'b0;
      w_start      = 1'b0;
      w_finish     = 1'b0;
      w_abort      = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (w_access && w_aligned) begin
               w_start      = 1'b1;
               mem_stall    = 1'b1;
               w_next_state = ST_BUSY;
            end
         end
         ST_BUSY: begin
            // Ack wins over a simultaneous timeout: the data did arrive.
            if (mem_ack) begin
               w_finish     = 1'b1;
               w_next_state = ST_IDLE;
            end else if (w_expired) begin
               w_abort      = 1'b1;
               w_next_state = ST_IDLE;
            end else begin
               mem_stall    = 1'b1;
            end
         end
         default: begin
            w_next_state = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         mem_req        <= 1'b0;
         mem_we         <= 1'b0;
         mem_addr       <= '0;
         mem_wdata      <= '0;
         MW_MemtoReg    <= 1'b0;
         MW_RegWrite    <= 1'b0;
         MW_ALUout      <= '0;
         MW_MDout       <= '0;
         MW_RD          <= '0;
         misalign_err   <= 1'b0;
         bus_err        <= 1'b0;
         r_lat_memtoreg <= 1'b0;
         r_lat_regwrite <= 1'b0;
         r_lat_aluout   <= '0;
         r_lat_rd       <= '0;
      end else if (r_state == ST_IDLE) begin
         if (!w_access) begin
            MW_MemtoReg <= XM_MemtoReg;
            MW_RegWrite <= XM_RegWrite;
            MW_ALUout   <= ALUout;
            MW_RD       <= XM_RD;
         end else if (w_start) begin
            // Read+write together is treated as a write.
            mem_req        <= 1'b1;
            mem_we         <= XM_MemWrite;
            mem_addr       <= ALUout;
            mem_wdata      <= XM_MD;
            r_lat_memtoreg <= XM_MemtoReg;
            r_lat_regwrite <= XM_RegWrite;
            r_lat_aluout   <= ALUout;
            r_lat_rd       <= XM_RD;
            MW_RegWrite    <= 1'b0;
         end else begin
            MW_RegWrite  <= 1'b0;
            misalign_err <= 1'b1;
         end
      end else begin
         if (w_finish) begin
            mem_req     <= 1'b0;
            MW_MemtoReg <= r_lat_memtoreg;
            MW_RegWrite <= r_lat_regwrite;
            MW_ALUout   <= r_lat_aluout;
            MW_RD       <= r_lat_rd;
            if (!mem_we) begin
               MW_MDout <= mem_rdata;
            end
         end else if (w_abort) begin
            mem_req     <= 1'b0;
            MW_RegWrite <= 1'b0;
            bus_err     <= 1'b1;
         end
      end
   end

   assign pc_redirect = XM_branch & (r_state == ST_IDLE);
   assign redirect_pc = XM_BT;

endmodule : mem_access_stage
`default_nettype wire

// File: tb/tb_mem_access_stage.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module : tb_mem_access_stage                                         |
// | Brief  : Directed vector table for single-cycle IDLE behaviour plus  |
// |          hand-written load / store / timeout / reset sequences.      |
// | Rev    : 1.0  initial release                                        |
// +----------------------------------------------------------------------+
module tb_mem_access_stage;

   logic        clk;
   logic        rst;
   logic        XM_MemtoReg, XM_RegWrite, XM_MemRead, XM_MemWrite, XM_branch;
   logic [31:0] ALUout, XM_MD, XM_BT;
   logic [4:0]  XM_RD;
   logic        mem_req, mem_we, mem_ack;
   logic [31:0] mem_addr, mem_wdata, mem_rdata;
   logic        MW_MemtoReg, MW_RegWrite;
   logic [31:0] MW_ALUout, MW_MDout;
   logic [4:0]  MW_RD;
   logic        mem_stall, pc_redirect, misalign_err, bus_err;
   logic [31:0] redirect_pc;

   int n_vec;
   int n_fail;

   mem_access_stage #(
      .TIMEOUT (15)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .XM_MemtoReg  (XM_MemtoReg),
      .XM_RegWrite  (XM_RegWrite),
      .XM_MemRead   (XM_MemRead),
      .XM_MemWrite  (XM_MemWrite),
      .XM_branch    (XM_branch),
      .ALUout       (ALUout),
      .XM_MD        (XM_MD),
      .XM_RD        (XM_RD),
      .XM_BT        (XM_BT),
      .mem_req      (mem_req),
      .mem_we       (mem_we),
      .mem_addr     (mem_addr),
      .mem_wdata    (mem_wdata),
      .mem_ack      (mem_ack),
      .mem_rdata    (mem_rdata),
      .MW_MemtoReg  (MW_MemtoReg),
      .MW_RegWrite  (MW_RegWrite),
      .MW_ALUout    (MW_ALUout),
      .MW_MDout     (MW_MDout),
      .MW_RD        (MW_RD),
      .mem_stall    (mem_stall),
      .pc_redirect  (pc_redirect),
      .redirect_pc  (redirect_pc),
      .misalign_err (misalign_err),
      .bus_err      (bus_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic        mt, rw, mrd, mwr, br;
      logic [31:0] alu, md, bt;
      logic [4:0]  rd;
      logic        e_stall, e_redir, e_mw_rw, e_mw_mt, chk_mw;
      logic [31:0] e_alu;
      logic [4:0]  e_rd;
      logic        e_mis;
   } vec_t;

   vec_t vt[6];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic mt, input logic rw, input logic mrd, input logic mwr,
                        input logic br, input logic [31:0] alu, input logic [31:0] md,
                        input logic [4:0] rd, input logic [31:0] bt);
      XM_MemtoReg = mt;
      XM_RegWrite = rw;
      XM_MemRead  = mrd;
      XM_MemWrite = mwr;
      XM_branch   = br;
      ALUout      = alu;
      XM_MD       = md;
      XM_RD       = rd;
      XM_BT       = bt;
   endtask

   task automatic nop();
      drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 5'd0, 32'h0);
   endtask

   initial begin
      n_vec   = 0;
      n_fail  = 0;
      rst     = 1'b1;
      mem_ack = 1'b0;
      mem_rdata = 32'h0;
      nop();

      //                mt  rw  mrd mwr br  alu           md       bt        rd     stl rdr mwrw mwmt chk e_alu        e_rd   mis
      vt[0] = '{1'b0,1'b1,1'b0,1'b0,1'b0,32'h10,       32'h0,   32'h0,    5'd5,  1'b0,1'b0,1'b1,1'b0,1'b1,32'h10,       5'd5,  1'b0};
      vt[1] = '{1'b1,1'b0,1'b0,1'b0,1'b0,32'hABCD0001, 32'h0,   32'h0,    5'd31, 1'b0,1'b0,1'b0,1'b1,1'b1,32'hABCD0001, 5'd31, 1'b0};
      vt[2] = '{1'b0,1'b1,1'b0,1'b0,1'b1,32'h20,       32'h0,   32'h100,  5'd3,  1'b0,1'b1,1'b1,1'b0,1'b1,32'h20,       5'd3,  1'b0};
      vt[3] = '{1'b1,1'b1,1'b1,1'b0,1'b0,32'h42,       32'h0,   32'h0,    5'd7,  1'b0,1'b0,1'b0,1'b0,1'b0,32'h0,        5'd0,  1'b1};
      vt[4] = '{1'b0,1'b0,1'b1,1'b1,1'b0,32'h43,       32'h99,  32'h0,    5'd0,  1'b0,1'b0,1'b0,1'b0,1'b0,32'h0,        5'd0,  1'b1};
      vt[5] = '{1'b0,1'b1,1'b0,1'b0,1'b0,32'h55,       32'h0,   32'h0,    5'd9,  1'b0,1'b0,1'b1,1'b0,1'b1,32'h55,       5'd9,  1'b1};

      // Reset state
      tick();
      tick();
      chk("rst_mem_req",   mem_req,      1'b0);
      chk("rst_mem_we",    mem_we,       1'b0);
      chk("rst_mem_addr",  mem_addr,     32'h0);
      chk("rst_mw_rw",     MW_RegWrite,  1'b0);
      chk("rst_mw_alu",    MW_ALUout,    32'h0);
      chk("rst_mw_md",     MW_MDout,     32'h0);
      chk("rst_misalign",  misalign_err, 1'b0);
      chk("rst_bus_err",   bus_err,      1'b0);
      chk("rst_stall",     mem_stall,    1'b0);
      rst = 1'b0;

      // Single-cycle IDLE vectors
      for (int i = 0; i < 6; i++) begin
         drive(vt[i].mt, vt[i].rw, vt[i].mrd, vt[i].mwr, vt[i].br,
               vt[i].alu, vt[i].md, vt[i].rd, vt[i].bt);
         #1;
         chk($sformatf("v%0d_stall", i),  mem_stall,   vt[i].e_stall);
         chk($sformatf("v%0d_redir", i),  pc_redirect, vt[i].e_redir);
         chk($sformatf("v%0d_rpc", i),    redirect_pc, vt[i].bt);
         tick();
         chk($sformatf("v%0d_req", i),    mem_req,      1'b0);
         chk($sformatf("v%0d_mw_rw", i),  MW_RegWrite,  vt[i].e_mw_rw);
         chk($sformatf("v%0d_mis", i),    misalign_err, vt[i].e_mis);
         chk($sformatf("v%0d_mw_md", i),  MW_MDout,     32'h0);
         if (vt[i].chk_mw) begin
            chk($sformatf("v%0d_mw_alu", i), MW_ALUout,   vt[i].e_alu);
            chk($sformatf("v%0d_mw_rd", i),  MW_RD,       {27'h0, vt[i].e_rd});
            chk($sformatf("v%0d_mw_mt", i),  MW_MemtoReg, vt[i].e_mw_mt);
         end
      end

      // Error flags are cleared only by reset
      nop();
      rst = 1'b1;
      #1;
      chk("rst2_misalign", misalign_err, 1'b0);
      rst = 1'b0;
      tick();

      // Load at 0x40, ack in the third BUSY cycle
      drive(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 32'h40, 32'h0, 5'd12, 32'h0);
      #1;
      chk("ld_stall_idle", mem_stall, 1'b1);
      tick();
      chk("ld_b1_req",   mem_req,     1'b1);
      chk("ld_b1_addr",  mem_addr,    32'h40);
      chk("ld_b1_we",    mem_we,      1'b0);
      chk("ld_b1_mw_rw", MW_RegWrite, 1'b0);
      chk("ld_b1_stall", mem_stall,   1'b1);
      XM_branch = 1'b1;
      XM_BT     = 32'h100;
      #1;
      chk("ld_busy_redir", pc_redirect, 1'b0);
      tick();
      chk("ld_b2_req",   mem_req,     1'b1);
      chk("ld_b2_stall", mem_stall,   1'b1);
      tick();
      chk("ld_b3_req",   mem_req,     1'b1);
      mem_ack   = 1'b1;
      mem_rdata = 32'hDEADBEEF;
      #1;
      chk("ld_ack_stall", mem_stall, 1'b0);
      tick();
      mem_ack   = 1'b0;
      mem_rdata = 32'h0;
      nop();
      chk("ld_done_req",  mem_req,     1'b0);
      chk("ld_mw_md",     MW_MDout,    32'hDEADBEEF);
      chk("ld_mw_rw",     MW_RegWrite, 1'b1);
      chk("ld_mw_mt",     MW_MemtoReg, 1'b1);
      chk("ld_mw_alu",    MW_ALUout,   32'h40);
      chk("ld_mw_rd",     {27'h0, MW_RD}, 32'd12);

      // Branch redirect in IDLE, stray ack in IDLE ignored
      XM_branch = 1'b1;
      XM_BT     = 32'h100;
      mem_ack   = 1'b1;
      mem_rdata = 32'h55555555;
      #1;
      chk("idle_redir",    pc_redirect, 1'b1);
      chk("idle_rpc",      redirect_pc, 32'h100);
      tick();
      mem_ack = 1'b0;
      nop();
      chk("stray_ack_md",  MW_MDout, 32'hDEADBEEF);
      chk("stray_ack_req", mem_req,  1'b0);

      // Store (read+write both set) at 0x44, ack in first BUSY cycle
      drive(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 32'h44, 32'h1234, 5'd0, 32'h0);
      tick();
      chk("st_req",   mem_req,   1'b1);
      chk("st_we",    mem_we,    1'b1);
      chk("st_addr",  mem_addr,  32'h44);
      chk("st_wdata", mem_wdata, 32'h1234);
      mem_ack   = 1'b1;
      mem_rdata = 32'hCAFEF00D;
      #1;
      chk("st_ack_stall", mem_stall, 1'b0);
      tick();
      mem_ack = 1'b0;
      nop();
      chk("st_done_req", mem_req,     1'b0);
      chk("st_mw_md",    MW_MDout,    32'hDEADBEEF);
      chk("st_mw_alu",   MW_ALUout,   32'h44);
      chk("st_mw_rw",    MW_RegWrite, 1'b0);

      // Load with no ack: timeout after 15 BUSY cycles
      drive(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 32'h80, 32'h0, 5'd4, 32'h0);
      tick();
      for (int c = 1; c <= 15; c++) begin
         chk($sformatf("to_c%0d_req", c),   mem_req,   1'b1);
         chk($sformatf("to_c%0d_stall", c), mem_stall, (c < 15) ? 1'b1 : 1'b0);
         tick();
      end
      nop();
      chk("to_req",     mem_req,     1'b0);
      chk("to_bus_err", bus_err,     1'b1);
      chk("to_mw_rw",   MW_RegWrite, 1'b0);
      chk("to_mis",     misalign_err, 1'b0);
      tick();
      chk("to_bus_sticky", bus_err, 1'b1);

      // Asynchronous reset in the middle of BUSY
      drive(1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 32'h90, 32'h0, 5'd6, 32'h200);
      tick();
      tick();
      chk("mr_req_before", mem_req, 1'b1);
      #2;
      rst = 1'b1;
      #1;
      chk("mr_req",     mem_req,     1'b0);
      chk("mr_idle",    pc_redirect, 1'b1);
      chk("mr_bus_err", bus_err,     1'b0);
      chk("mr_mw_md",   MW_MDout,    32'h0);
      nop();
      #1;
      rst = 1'b0;
      tick();
      chk("mr_after_req", mem_req, 1'b0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
      $finish;
   end

endmodule : tb_mem_access_stage
`default_nettype wire

// File: doc/mem_access_stage.md
MEM_ACCESS_STAGE -- requirements
Module: mem_access_stage

Interface
REQ-001 Parameter TIMEOUT, default 15, meaning max BUSY cycles waiting for mem_ack before abort.
REQ-002 clk  input  1  sole clock; all state updates on its rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-high.
REQ-004 XM_MemtoReg, XM_RegWrite, XM_MemRead, XM_MemWrite, XM_branch  input  1 each  EX/MEM control bits.
REQ-005 ALUout  input  32  ALU result; byte address for loads and stores.
REQ-006 XM_MD  input  32  store data;  XM_RD  input  5  destination register;  XM_BT  input  32  branch target.
REQ-007 mem_req  output  1; mem_we  output  1; mem_addr  output  32; mem_wdata  output  32  data-memory request, all registered.
REQ-008 mem_ack  input  1  one-cycle completion strobe; mem_rdata  input  32  load data, valid with mem_ack.
REQ-009 MW_MemtoReg, MW_RegWrite  output  1 each; MW_ALUout, MW_MDout  output  32 each; MW_RD  output  5  MEM/WB register.
REQ-010 mem_stall  output  1  combinational; upstream holds EX/MEM while high.
REQ-011 pc_redirect  output  1; redirect_pc  output  32  combinational branch redirect.
REQ-012 misalign_err, bus_err  output  1 each  sticky error flags.

Function
REQ-013 States: IDLE, BUSY; access = XM_MemRead | XM_MemWrite; aligned = (ALUout[1:0] == 0).
REQ-014 IDLE, no access: at each edge, MW_* shall load XM_MemtoReg, XM_RegWrite, ALUout, XM_RD; MW_MDout is held; one-cycle latency.
REQ-015 IDLE, access and aligned: mem_stall=1; at the edge, mem_req<=1, mem_we<=XM_MemWrite, mem_addr<=ALUout, mem_wdata<=XM_MD; latch MemtoReg, RegWrite, ALUout, RD internally; MW_RegWrite<=0 (bubble); clear wait counter; go to BUSY.
REQ-016 IDLE, access and misaligned: no request; MW_RegWrite<=0; misalign_err<=1; stay IDLE; mem_stall=0.
REQ-017 XM_MemRead and XM_MemWrite both high shall be treated as a write.
REQ-018 BUSY: mem_req, mem_we, mem_addr and mem_wdata are held stable; MW_RegWrite stays 0; the wait counter increments each cycle without mem_ack.
REQ-019 BUSY with mem_ack=1: mem_stall=0; at the edge, the latched values go to MW_*; MW_MDout<=mem_rdata (only when the access was a read); mem_req<=0; go to IDLE.
REQ-020 BUSY with no ack and counter == TIMEOUT-1: mem_stall=0; at the edge, mem_req<=0; MW_RegWrite<=0; bus_err<=1; go to IDLE.
REQ-021 Otherwise in BUSY, mem_stall=1.
REQ-022 mem_ack while in IDLE shall be ignored.
REQ-023 pc_redirect = XM_branch & (state==IDLE); redirect_pc = XM_BT.
REQ-024 A store completes in BUSY with MW_MDout unchanged.

Reset
REQ-025 rst shall force IDLE, all registered outputs to 0, clear both error flags and the wait counter, and drop mem_req immediately, including during BUSY.
REQ-026 The error flags shall be cleared only by rst.

Structure
REQ-027 Package mem_stage_pkg shall hold the state enum, TIMEOUT default, address/data/register widths.
REQ-028 One sub-module, mem_wait_timer (clear, enable, expired), shall implement the wait counter.

Verification
REQ-029 ALU op, ALUout=0x10, XM_RD=5, RegWrite=1 -> next edge MW_ALUout=0x10, MW_RD=5, MW_RegWrite=1, mem_stall=0.
REQ-030 Load at 0x40, ack after 3 BUSY cycles with rdata=0xDEADBEEF -> mem_req high for 3 cycles with addr 0x40, we=0; then MW_MDout=0xDEADBEEF, MW_RegWrite=1.
REQ-031 Store at 0x44, XM_MD=0x1234, ack on first BUSY cycle -> mem_we=1, mem_wdata=0x1234; MW_MDout unchanged; mem_stall low in the ack cycle.
REQ-032 Load at 0x42 -> no mem_req; misalign_err=1; MW_RegWrite=0.
REQ-033 Load with no ack -> exits after 15 BUSY cycles; bus_err=1; MW_RegWrite=0. A separate run asserts rst mid-BUSY -> mem_req=0 and state IDLE immediately.
REQ-034 XM_branch=1, XM_BT=0x100 in IDLE -> pc_redirect=1, redirect_pc=0x100; the same inputs in BUSY give pc_redirect=0.
